// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and constants for the single-port memory arbiter:
//   - arb_state_t            : sequencer states (IDLE / DATA / FETCH)
//   - GRANT_DATA/GRANT_FETCH : encoding of the last_grant fairness bit
//   - TIMEOUT_CYCLES_DEFAULT : default watchdog limit (cycles per transaction)
//   - FETCH_BE               : byte enables driven for instruction fetches
//   - pick_grant()           : IDLE-state arbitration decision
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } arb_state_t;

  localparam logic GRANT_DATA  = 1'b0;
  localparam logic GRANT_FETCH = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  localparam logic [3:0] FETCH_BE = 4'hF;

  // Round-robin between the two requesters: a contested grant goes to the
  // side that did not win last time.
  function automatic arb_state_t pick_grant(input logic d_req,
                                            input logic if_req,
                                            input logic last_grant);
    arb_state_t s;
    s = ST_IDLE;
    if (d_req && (!if_req || (last_grant == GRANT_FETCH))) begin
      s = ST_DATA;
    end else if (if_req) begin
      s = ST_FETCH;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_arbiter_wdog.sv
// -----------------------------------------------------------------------------
// mem_arbiter_wdog
//   Per-transaction watchdog for mem_arbiter. A 16-bit counter is cleared when
//   a bus transaction starts and advances on every cycle the transaction is
//   waiting. o_expire fires on the cycle the count reaches TIMEOUT_CYCLES-1
//   while still waiting, i.e. on the TIMEOUT_CYCLES-th bus_valid cycle.
//
// Ports
//   clk       in   rising-edge clock
//   clr_n     in   asynchronous active-low reset
//   i_start   in   transaction is being granted this cycle (clears the count)
//   i_tick    in   transaction active and not completed this cycle
//   o_expire  out  abandon the transaction this cycle
// -----------------------------------------------------------------------------
module mem_arbiter_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_start,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expire = i_tick && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Single-port memory arbiter / sequencer for the 5-stage pipeline. Shares one
//   external memory bus between the IF-stage fetch port and the MEM-stage
//   load/store port, one transaction at a time, and raises stall requests to
//   the hazard unit until each access completes.
//
//   Optional feature: define MEM_ARBITER_WATCHDOG_EN to compile in a watchdog
//   that abandons a transaction after TIMEOUT_CYCLES bus_valid cycles without
//   bus_ready, returns a ready pulse with zero data and sets sticky bus_err.
//   Without it bus_err is 0 and the arbiter waits indefinitely.
//
// Ports
//   clk, clr_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and address (PCF)
//   if_ready/if_rdata     fetch completion pulse and instruction word
//   d_req/d_we/d_be       load/store request, write flag, byte enables
//   d_addr/d_wdata        data address and store data
//   d_ready/d_rdata       data completion pulse and load data
//   stall_if/stall_mem    hazard-unit stall requests
//   bus_valid/bus_we/bus_be/bus_addr/bus_wdata   bus transaction (registered)
//   bus_ready/bus_rdata   bus completion and read data
//   bus_err               sticky watchdog error flag
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_t  r_state;
  arb_state_t  w_next;
  logic        r_last_grant;

  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;

  logic        w_busy;
  logic        w_start;
  logic        w_expire;
  logic        w_finish;

  assign w_busy  = (r_state != ST_IDLE);
  assign w_start = (r_state == ST_IDLE) && (w_next != ST_IDLE);

`ifdef MEM_ARBITER_WATCHDOG_EN
  logic r_err;

  mem_arbiter_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .clr_n    (clr_n),
    .i_start  (w_start),
    .i_tick   (w_busy && !bus_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign bus_err = r_err;
`else
  assign w_expire = 1'b0;
  assign bus_err  = 1'b0;
`endif

  // A transaction ends either on a real bus response or on watchdog expiry;
  // only the former carries read data.
  assign w_finish = w_busy && (bus_ready || w_expire);

  // ---------------------------------------------------------------------------
  // State register and fairness bit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_FETCH;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_last_grant <= (w_next == ST_FETCH) ? GRANT_FETCH : GRANT_DATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus transaction fields: captured once at grant, held until completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_start) begin
      if (w_next == ST_DATA) begin
        r_bus_we    <= d_we;
        r_bus_be    <= d_be;
        r_bus_addr  <= d_addr;
        r_bus_wdata <= d_wdata;
      end else begin
        r_bus_we    <= 1'b0;
        r_bus_be    <= FETCH_BE;
        r_bus_addr  <= if_addr;
        r_bus_wdata <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and completion outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    d_ready  = 1'b0;
    d_rdata  = '0;
    if_ready = 1'b0;
    if_rdata = '0;

    case (r_state)
      ST_IDLE: begin
        w_next = pick_grant(d_req, if_req, r_last_grant);
      end

      ST_DATA: begin
        if (w_finish) begin
          w_next  = ST_IDLE;
          d_ready = 1'b1;
          d_rdata = bus_ready ? bus_rdata : '0;
        end
      end

      ST_FETCH: begin
        if (w_finish) begin
          w_next = ST_IDLE;
          // A fetch whose address was redirected or withdrawn while on the bus
          // still completes there; its response is simply not delivered.
          if (if_req && (if_addr == r_bus_addr)) begin
            if_ready = 1'b1;
            if_rdata = bus_ready ? bus_rdata : '0;
          end
        end
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign stall_if  = if_req && !if_ready;
  assign stall_mem = d_req && !d_ready;

  assign bus_valid = w_busy;
  assign bus_we    = r_bus_we;
  assign bus_be    = r_bus_be;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A transaction-level reference model (who owns the bus, what was
//   latched, how long it has waited) is stepped on every clock and checked
//   against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
`ifdef MEM_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        if_ready, d_ready, stall_if, stall_mem;
  logic        bus_valid, bus_we, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: owner 0 = none, 1 = data, 2 = fetch
  // ---------------------------------------------------------------------------
  int          m_owner = 0;
  bit          m_last_fetch = 1'b1;
  int          m_age = 0;          // completed waiting cycles of current txn
  bit          m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  function automatic bit m_timeout();
    return WD && (m_owner != 0) && !bus_ready && (m_age + 1 == int'(TO));
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_owner      <= 0;
      m_last_fetch <= 1'b1;
      m_age        <= 0;
      m_err        <= 1'b0;
      m_we         <= 1'b0;
      m_be         <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else if (m_owner == 0) begin
      if (d_req && (!if_req || m_last_fetch)) begin
        m_owner      <= 1;
        m_we         <= d_we;
        m_be         <= d_be;
        m_addr       <= d_addr;
        m_wdata      <= d_wdata;
        m_last_fetch <= 1'b0;
        m_age        <= 0;
      end else if (if_req) begin
        m_owner      <= 2;
        m_we         <= 1'b0;
        m_be         <= 4'hF;
        m_addr       <= if_addr;
        m_wdata      <= '0;
        m_last_fetch <= 1'b1;
        m_age        <= 0;
      end
    end else if (bus_ready || m_timeout()) begin
      m_owner <= 0;
      if (!bus_ready) m_err <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Every-cycle comparison against the model
  // ---------------------------------------------------------------------------
  bit          e_ok, e_fin, e_dr, e_ir;
  logic [31:0] e_drd, e_ird;

  always @(negedge clk) begin
    if (clr_n) begin
      e_ok  = (m_owner != 0) && bus_ready;
      e_fin = e_ok || m_timeout();
      e_dr  = (m_owner == 1) && e_fin;
      e_drd = ((m_owner == 1) && e_ok) ? bus_rdata : 32'h0;
      e_ir  = (m_owner == 2) && e_fin && if_req && (if_addr == m_addr);
      e_ird = (e_ir && e_ok) ? bus_rdata : 32'h0;
      chk1("m.bus_valid", bus_valid, m_owner != 0);
      chk1("m.d_ready", d_ready, e_dr);
      chk("m.d_rdata", d_rdata, e_drd);
      chk1("m.if_ready", if_ready, e_ir);
      chk("m.if_rdata", if_rdata, e_ird);
      chk1("m.stall_if", stall_if, if_req && !e_ir);
      chk1("m.stall_mem", stall_mem, d_req && !e_dr);
      chk1("m.bus_err", bus_err, m_err);
      if (m_owner != 0) begin
        chk1("m.bus_we", bus_we, m_we);
        chk({"m.bus_be"}, {28'b0, bus_be}, {28'b0, m_be});
        chk("m.bus_addr", bus_addr, m_addr);
        chk("m.bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    bus_ready = 1'b0;
    tick();
    tick();
  endtask

  bit          last_dr, last_ir;
  logic [31:0] pc;
  int          stall_run;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk1("rst.bus_valid_in_reset", bus_valid, 1'b0);
    chk("rst.bus_addr_in_reset", bus_addr, 32'h0);
    clr_n = 1'b1;
    sample();
    chk1("rst.bus_valid", bus_valid, 1'b0);
    chk1("rst.d_ready", d_ready, 1'b0);
    chk1("rst.if_ready", if_ready, 1'b0);
    chk1("rst.bus_err", bus_err, 1'b0);
    chk("rst.bus_wdata", bus_wdata, 32'h0);
    tick();

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h100; bus_ready = 1'b0;
    sample();
    chk1("fetch.stall_if_idle", stall_if, 1'b1);
    chk1("fetch.valid_idle", bus_valid, 1'b0);
    tick();
    bus_ready = 1'b1; bus_rdata = 32'h00500093;
    sample();
    chk1("fetch.valid", bus_valid, 1'b1);
    chk("fetch.bus_addr", bus_addr, 32'h100);
    chk1("fetch.bus_we", bus_we, 1'b0);
    chk1("fetch.if_ready", if_ready, 1'b1);
    chk("fetch.if_rdata", if_rdata, 32'h00500093);
    chk1("fetch.stall_if_done", stall_if, 1'b0);
    tick();
    if_req = 1'b0; bus_ready = 1'b0;
    sample();
    chk1("fetch.gap_valid", bus_valid, 1'b0);
    tick();

    // Contention fairness from reset
    clr_n = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000;
    if_req = 1'b1; if_addr = 32'h100;
    bus_ready = 1'b1; bus_rdata = 32'h1234;
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk1("fair.valid_pattern", bus_valid, (i % 2) == 1);
      if ((i % 2) == 1)
        chk("fair.grant_addr", bus_addr, ((i == 1) || (i == 5)) ? 32'h4000 : 32'h100);
      tick();
    end
    quiet();

    // Store with 3 wait cycles
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1100; d_addr = 32'h2002; d_wdata = 32'hABCD0000;
    bus_ready = 1'b0;
    sample();
    chk1("store.valid_idle", bus_valid, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus_ready = (k == 4);
      sample();
      chk1("store.valid", bus_valid, 1'b1);
      chk1("store.we", bus_we, 1'b1);
      chk("store.be", {28'b0, bus_be}, 32'hC);
      chk("store.addr", bus_addr, 32'h2002);
      chk("store.wdata", bus_wdata, 32'hABCD0000);
      chk1("store.d_ready", d_ready, k == 4);
    end
    tick();
    d_req = 1'b0; d_we = 1'b0; bus_ready = 1'b0;
    sample();
    chk1("store.gap_valid", bus_valid, 1'b0);
    tick();

    // Flushed fetch
    if_req = 1'b1; if_addr = 32'h200; bus_ready = 1'b0;
    sample();
    tick();
    sample();
    chk("flush.first_addr", bus_addr, 32'h200);
    tick();
    if_addr = 32'h300; bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    sample();
    chk1("flush.no_if_ready", if_ready, 1'b0);
    chk("flush.if_rdata_zero", if_rdata, 32'h0);
    chk1("flush.stall_if", stall_if, 1'b1);
    tick();
    bus_ready = 1'b0;
    sample();
    chk1("flush.gap_valid", bus_valid, 1'b0);
    tick();
    bus_ready = 1'b1; bus_rdata = 32'h00A00113;
    sample();
    chk("flush.refetch_addr", bus_addr, 32'h300);
    chk1("flush.refetch_ready", if_ready, 1'b1);
    chk("flush.refetch_rdata", if_rdata, 32'h00A00113);
    tick();
    quiet();

    // Reset during DATA
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; bus_ready = 1'b0;
    sample();
    tick();
    sample();
    chk1("rstmid.valid_before", bus_valid, 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk1("rstmid.valid_now", bus_valid, 1'b0);
    chk1("rstmid.d_ready", d_ready, 1'b0);
    chk("rstmid.bus_addr", bus_addr, 32'h0);
    tick();
    d_req = 1'b0;
    clr_n = 1'b1;
    sample();
    chk1("rstmid.valid_after", bus_valid, 1'b0);
    chk1("rstmid.d_ready_after", d_ready, 1'b0);
    tick();

`ifdef MEM_ARBITER_WATCHDOG_EN
    // Watchdog expiry with TIMEOUT_CYCLES = 8
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; bus_ready = 1'b0;
    sample();
    for (int k = 1; k <= 8; k++) begin
      tick();
      sample();
      chk1("wd.valid", bus_valid, 1'b1);
      chk1("wd.d_ready", d_ready, k == 8);
      chk1("wd.err_before", bus_err, 1'b0);
      if (k == 8) chk("wd.d_rdata", d_rdata, 32'h0);
    end
    tick();
    d_req = 1'b0;
    sample();
    chk1("wd.valid_after", bus_valid, 1'b0);
    chk1("wd.err_set", bus_err, 1'b1);
    tick();
    d_req = 1'b1; d_addr = 32'h5004; bus_ready = 1'b1; bus_rdata = 32'h77;
    sample();
    tick();
    sample();
    chk1("wd.good_ready", d_ready, 1'b1);
    chk("wd.good_rdata", d_rdata, 32'h77);
    chk1("wd.err_sticky", bus_err, 1'b1);
    tick();
    quiet();
`endif

    // Randomized phase
    last_dr   = 1'b0;
    last_ir   = 1'b0;
    pc        = 32'h1000;
    stall_run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!(d_req && !last_dr)) begin
        d_req   = ($urandom_range(2) == 0);
        d_we    = 1'($urandom);
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (last_ir) pc = pc + 32'd4;
      case ($urandom_range(15))
        0:       pc = {$urandom_range(255), 8'h00} + 32'h1000;
        1:       if_req = 1'b0;
        default: if_req = ($urandom_range(3) != 0);
      endcase
      if_addr = pc;
      if (stall_run == 0 && $urandom_range(49) == 0) stall_run = 12;
      if (stall_run > 0) begin
        bus_ready = 1'b0;
        stall_run--;
      end else begin
        bus_ready = 1'($urandom);
      end
      bus_rdata = $urandom;
      sample();
      last_dr = d_ready;
      last_ir = if_ready;
      tick();
    end
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
